// File: rtl/lh_lane_fifo_pkg.sv
// Shared constants and helpers for the two-lane Low/High partitioned FIFO.
// Lane indices are fixed: LANE_L carries Low data, LANE_H carries High data.
package lh_lane_fifo_pkg;

   localparam int unsigned LANE_L    = 0;
   localparam int unsigned LANE_H    = 1;
   localparam int unsigned NUM_LANES = 2;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 4;

   // Ceiling log2, usable in parameter defaults.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((64'd1 << r) < 64'(n)) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lh_lane_fifo_core.sv
// Single-lane show-ahead FIFO; the top instantiates one per security lane so
// no storage, pointer or control state is ever shared between labels.
module lh_lane_fifo_core
   import lh_lane_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push, pop, we;

   // in_ready is forced low while reset is held so no push can be inferred.
   assign in_ready_o  = ~reset_i & (count_q != CountFull);
   assign out_valid_o = (count_q != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign we          = push & ~flush_i;
   assign out_data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(push);
         rd_ptr_d = rd_ptr_q + AW'(pop);
         count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; out_valid gates its visibility.
   always_ff @(posedge clk_i) begin
      if (we) mem_q[wr_ptr_q] <= in_data_i;
   end

endmodule

// File: rtl/lh_lane_fifo.sv
// Two-lane Low/High FIFO: lane 0 holds {L} data, lane 1 holds {H} data, fully independent.
// Optional per-lane synchronous flush input is enabled by defining LH_LANE_FLUSH_EN.
module lh_lane_fifo
   import lh_lane_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
`ifdef LH_LANE_FLUSH_EN
   input  logic [1:0]       flush,
`endif
   input  logic [1:0]       in_valid,
   output logic [1:0]       in_ready,
   input  logic [WIDTH-1:0] in_data_lo,
   input  logic [WIDTH-1:0] in_data_hi,
   output logic [1:0]       out_valid,
   input  logic [1:0]       out_ready,
   output logic [WIDTH-1:0] out_data_lo,
   output logic [WIDTH-1:0] out_data_hi
);

   logic flush_lo;
   logic flush_hi;

`ifdef LH_LANE_FLUSH_EN
   assign flush_lo = flush[LANE_L];
   assign flush_hi = flush[LANE_H];
`else
   assign flush_lo = 1'b0;
   assign flush_hi = 1'b0;
`endif

   // Each lane sees only its own bit of every handshake vector.
   lh_lane_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_lane_lo (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush_lo),
      .in_valid_i  (in_valid[LANE_L]),
      .in_ready_o  (in_ready[LANE_L]),
      .in_data_i   (in_data_lo),
      .out_valid_o (out_valid[LANE_L]),
      .out_ready_i (out_ready[LANE_L]),
      .out_data_o  (out_data_lo)
   );

   lh_lane_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_lane_hi (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush_hi),
      .in_valid_i  (in_valid[LANE_H]),
      .in_ready_o  (in_ready[LANE_H]),
      .in_data_i   (in_data_hi),
      .out_valid_o (out_valid[LANE_H]),
      .out_ready_i (out_ready[LANE_H]),
      .out_data_o  (out_data_hi)
   );

endmodule

// File: tb/tb_lh_lane_fifo.sv
// Scoreboard bench for lh_lane_fifo: per-lane queue models fed on accepted pushes,
// a negedge monitor checks handshakes and head data. Honours LH_LANE_FLUSH_EN.
module tb_lh_lane_fifo;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] in_valid = 2'b00;
   logic [1:0] out_ready = 2'b00;
   logic [7:0] in_data_lo = 8'h00;
   logic [7:0] in_data_hi = 8'h00;
   logic [1:0] in_ready;
   logic [1:0] out_valid;
   logic [7:0] out_data_lo;
   logic [7:0] out_data_hi;
`ifdef LH_LANE_FLUSH_EN
   logic [1:0] flush = 2'b00;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int occ0 = 0;
   int occ1 = 0;
   bit started = 0;
   logic [7:0] sbq0[$];
   logic [7:0] sbq1[$];

   lh_lane_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH),
      .AW    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
`ifdef LH_LANE_FLUSH_EN
      .flush       (flush),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data_lo  (in_data_lo),
      .in_data_hi  (in_data_hi),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data_lo (out_data_lo),
      .out_data_hi (out_data_hi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: each lane is an ordered queue of at most DEPTH items.
   always @(posedge clk) begin
      if (reset) begin
         started = 1;
         occ0 = 0;
         occ1 = 0;
         sbq0.delete();
         sbq1.delete();
      end else if (started) begin
         bit fl0, fl1, pu, po;
         fl0 = 0;
         fl1 = 0;
`ifdef LH_LANE_FLUSH_EN
         fl0 = flush[0];
         fl1 = flush[1];
`endif
         if (fl0) begin
            occ0 = 0;
            sbq0.delete();
         end else begin
            pu = in_valid[0] && occ0 < DEPTH;
            po = out_ready[0] && occ0 > 0;
            if (pu) sbq0.push_back(in_data_lo);
            occ0 = occ0 + int'(pu) - int'(po);
         end
         if (fl1) begin
            occ1 = 0;
            sbq1.delete();
         end else begin
            pu = in_valid[1] && occ1 < DEPTH;
            po = out_ready[1] && occ1 > 0;
            if (pu) sbq1.push_back(in_data_hi);
            occ1 = occ1 + int'(pu) - int'(po);
         end
      end
   end

   // Monitor: queue front is the item the DUT must be presenting this cycle.
   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 32'(in_ready),
             reset ? 32'd0 : 32'({occ1 < DEPTH, occ0 < DEPTH}));
         chk("out_valid", 32'(out_valid), 32'({occ1 > 0, occ0 > 0}));
         if (occ0 > 0) begin
            chk("lo_head", 32'(out_data_lo), 32'(sbq0[0]));
            if (out_ready[0] && !reset) void'(sbq0.pop_front());
         end
         if (occ1 > 0) begin
            chk("hi_head", 32'(out_data_hi), 32'(sbq1[0]));
            if (out_ready[1] && !reset) void'(sbq1.pop_front());
         end
      end
   end

   task automatic drive(input logic rst, input logic [1:0] iv, input logic [1:0] ordy,
                        input logic [7:0] dlo, input logic [7:0] dhi);
      @(posedge clk);
      #1;
      reset      = rst;
      in_valid   = iv;
      out_ready  = ordy;
      in_data_lo = dlo;
      in_data_hi = dhi;
`ifdef LH_LANE_FLUSH_EN
      flush      = 2'b00;
`endif
   endtask

   initial begin
      drive(1, 2'b00, 2'b00, 8'h00, 8'h00);
      drive(1, 2'b00, 2'b00, 8'h00, 8'h00);
      // Lane 0 basic push/pop
      drive(0, 2'b01, 2'b00, 8'h11, 8'h00);
      drive(0, 2'b01, 2'b00, 8'h22, 8'h00);
      drive(0, 2'b00, 2'b01, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b01, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      // Fill lane 1, fifth push refused
      for (int k = 0; k < 5; k++) drive(0, 2'b10, 2'b00, 8'h00, 8'(8'hA0 + k));
      // Full with push and pop together
      drive(0, 2'b10, 2'b10, 8'h00, 8'hA5);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      for (int k = 0; k < 3; k++) drive(0, 2'b00, 2'b10, 8'h00, 8'h00);
      // Lane 0 wrap: values 1..6 interleaved
      drive(0, 2'b01, 2'b00, 8'd1, 8'h00);
      for (int v = 2; v <= 6; v++) drive(0, 2'b01, 2'b01, 8'(v), 8'h00);
      drive(0, 2'b00, 2'b01, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      // Reset with lane 0 = 3 entries, lane 1 = 2 entries
      drive(0, 2'b11, 2'b00, 8'h31, 8'h41);
      drive(0, 2'b11, 2'b00, 8'h32, 8'h42);
      drive(0, 2'b01, 2'b00, 8'h33, 8'h00);
      drive(1, 2'b11, 2'b11, 8'h55, 8'h66);
      drive(1, 2'b00, 2'b00, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
`ifdef LH_LANE_FLUSH_EN
      // Flush lane 1 with a concurrent push; lane 0 must keep its entry
      drive(0, 2'b11, 2'b00, 8'h71, 8'h81);
      drive(0, 2'b10, 2'b00, 8'h00, 8'h82);
      drive(0, 2'b10, 2'b00, 8'h00, 8'h83);
      flush = 2'b10;
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b01, 8'h00, 8'h00);
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
`endif
      // Randomized phases with varying push/pop pressure
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 750; c++) begin
            logic [1:0] iv, ordy;
            logic rst;
            iv   = {($urandom_range(3) < 3 - ph % 2), ($urandom_range(3) < 1 + ph % 3)};
            ordy = {($urandom_range(3) < 1 + ph), ($urandom_range(3) < 3 - ph)};
            rst  = ($urandom_range(127) == 0);
            drive(rst, iv, ordy, 8'($urandom), 8'($urandom));
`ifdef LH_LANE_FLUSH_EN
            flush = {($urandom_range(31) == 0), ($urandom_range(31) == 0)};
`endif
         end
      end
      drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
